// File: rtl/instr_loader.sv
// Streams a program into the cell chain one word per cycle, issues a call, then waits for ret.
// Accepted words appear one cycle later; prog_ready is high only while loading.
module instr_loader #(
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int MAX_WORDS        = 1024,
  parameter int TIMEOUT_CYCLES   = 65535,
  localparam int CW = $clog2(MAX_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        prog_valid,
  output logic                        prog_ready,
  input  logic [INSTR_DATA_WIDTH-1:0] prog_data,
  input  logic [INSTR_ADDR_WIDTH-1:0] prog_addr,
  input  logic [INSTR_HOPS_WIDTH-1:0] prog_hops,
  input  logic                        prog_last,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        instr_en_out,
  output logic                        call_out,
  input  logic                        ret_in,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [CW-1:0]               word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_WORDS);
  localparam logic [CW-1:0] LAST_W  = CW'(MAX_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALL, WAIT_RET, FINISH} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;

  assign prog_ready = (state == LOAD);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tcnt           <= '0;
      instr_data_out <= '0;
      instr_addr_out <= '0;
      instr_hops_out <= '0;
      instr_en_out   <= 1'b0;
      call_out       <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      word_count     <= '0;
    end else begin
      instr_en_out <= 1'b0;
      call_out     <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            error      <= 1'b0;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            instr_data_out <= prog_data;
            instr_addr_out <= prog_addr;
            instr_hops_out <= prog_hops;
            instr_en_out   <= 1'b1;
            if (word_count != MAX_W) word_count <= word_count + 1'b1;
            // An unterminated program that fills the budget is still called, but flagged.
            if (prog_last) begin
              state <= CALL;
            end else if (word_count == LAST_W) begin
              error <= 1'b1;
              state <= CALL;
            end
          end
        end
        CALL: begin
          call_out <= 1'b1;
          tcnt     <= '0;
          state    <= WAIT_RET;
        end
        WAIT_RET: begin
          // ret on the final allowed cycle wins over the timeout.
          if (ret_in) begin
            state <= FINISH;
          end else if (tcnt == TO_LAST) begin
            error <= 1'b1;
            state <= FINISH;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction word width.
REQ-002 The block SHALL have parameter INSTR_ADDR_WIDTH, default 6, slot-local instruction address width.
REQ-003 The block SHALL have parameter INSTR_HOPS_WIDTH, default 4, cell-chain hop count width.
REQ-004 The block SHALL have parameter MAX_WORDS, default 1024, maximum words per program.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, ret wait limit.
REQ-006 The block SHALL have ports, one per line:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin program load, single-cycle pulse
- prog_valid  in  1  program word valid
- prog_ready  out  1  program word accepted when high with prog_valid
- prog_data  in  INSTR_DATA_WIDTH  instruction word
- prog_addr  in  INSTR_ADDR_WIDTH  target instruction address
- prog_hops  in  INSTR_HOPS_WIDTH  target cell distance in chain
- prog_last  in  1  final word of program
- instr_data_out  out  INSTR_DATA_WIDTH  to first cell instr_data_in
- instr_addr_out  out  INSTR_ADDR_WIDTH  to first cell instr_addr_in
- instr_hops_out  out  INSTR_HOPS_WIDTH  to first cell instr_hops_in
- instr_en_out  out  1  to first cell instr_en_in
- call_out  out  1  to first cell call_in
- ret_in  in  1  from last cell ret_out, level
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky fault flag
- word_count  out  clog2(MAX_WORDS+1)  words issued in current/last program

Function
REQ-007 FSM states SHALL be IDLE, LOAD, CALL, WAIT_RET, FINISH.
REQ-008 IDLE: start=1 SHALL go to LOAD next cycle, clear word_count and error.
REQ-009 start outside IDLE SHALL be ignored.
REQ-010 prog_ready SHALL be 1 only in LOAD; combinational from state only, never from prog_valid.
REQ-011 Accepted word (prog_valid & prog_ready) SHALL appear on instr_*_out with instr_en_out=1 on the following cycle, exactly one cycle; instr_en_out=0 otherwise.
REQ-012 instr_data/addr/hops_out SHALL hold last issued values while instr_en_out=0.
REQ-013 Each accepted word SHALL increment word_count by 1; word_count SHALL saturate at MAX_WORDS.
REQ-014 Accepted word with prog_last=1 SHALL move LOAD to CALL.
REQ-015 Accepting word number MAX_WORDS with prog_last=0 SHALL set error, issue that word, and move to CALL (no further words accepted).
REQ-016 CALL SHALL last one cycle, drive call_out=1, enter WAIT_RET; call_out=0 in all other states; call_out asserts one cycle after last instr_en_out.
REQ-017 ret_in SHALL be sampled only in WAIT_RET; ret_in in other states ignored.
REQ-018 WAIT_RET: ret_in=1 SHALL go to FINISH next cycle.
REQ-019 WAIT_RET timeout counter SHALL clear on entry, increment per cycle; reaching TIMEOUT_CYCLES without ret_in SHALL set error and go to FINISH.
REQ-020 ret_in=1 on the timeout cycle SHALL take precedence: no error.
REQ-021 FINISH SHALL last one cycle with done=1, then IDLE; start in FINISH ignored.
REQ-022 error SHALL stay set until next accepted start or reset.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE; prog_ready, instr_en_out, call_out, busy, done, error =0; instr_*_out, word_count, timeout counter =0.
REQ-024 Reset mid-LOAD or mid-WAIT_RET SHALL abandon program; no instr_en_out or call_out pulse after release until new start.

Verification
REQ-025 start, 3 words (addr 0,1,2, hops 1,2,3, last on 3rd), valid continuous -> instr_en_out high 3 cycles matching words, call_out 1 cycle later, word_count=3.
REQ-026 After REQ-025, ret_in high 5 cycles into WAIT_RET -> done pulse next-next cycle, busy low after, error=0.
REQ-027 TIMEOUT_CYCLES=8, ret_in never -> error=1 and done at cycle 8 of WAIT_RET; ret_in raised at cycle 8 exactly -> error=0.
REQ-028 MAX_WORDS=4, 6 words no last -> 4 issued, prog_ready low after 4th, error=1, call_out issued.
REQ-029 prog_valid toggling 1/0 with start during LOAD -> instr_en_out only for accepted words, start ignored, count correct.
REQ-030 rst_n low during WAIT_RET, then ret_in high -> no done, all outputs at reset values, IDLE.
